image_tile_loader: RTL and testbench
====================================

// Module: image_tile_loader
// PURPOSE
//  Upstream stage of edge_detector. Converts a raster pixel stream (valid/ready) into a full
//  HEIGHT x WIDTH tile presented in parallel on image_out / image_out_valid. Ping-pong double
//  buffer: the next tile fills while the current tile is held for the pipeline.
// PARAMETERS
//  HEIGHT       50  tile rows
//  WIDTH        50  tile columns
//  PIXEL_WIDTH  8   bits per pixel
// PORTS
//  clk             in   1                      rising-edge clock
//  reset_n         in   1                      asynchronous active-low reset
//  enable          in   1                      0 = stall input side (ready low, counters held)
//  pix_in          in   PIXEL_WIDTH            raster pixel, row-major, col fastest
//  pix_in_valid    in   1                      pix_in valid
//  pix_in_sof      in   1                      marks pixel (0,0) of a tile; qualified by valid
//  pix_in_ready    out  1                      = enable & ~full[wr_bank]
//  image_out       out  PIXEL_WIDTH x H x W    [HEIGHT-1:0][WIDTH-1:0] presented tile, 0 when not valid
//  image_out_valid out  1                      = full[rd_bank]
//  image_out_ack   in   1                      1-cycle pulse: downstream finished with tile
//  frame_err       out  1                      1-cycle pulse: sof received mid-tile
//  tiles_loaded    out  16                     count of completed tiles, wraps at 2^16
// BEHAVIOUR
//  Reset (async, reset_n=0): wr_bank=rd_bank=0, full=2'b00, row=col=0, state=IDLE,
//   frame_err=0, tiles_loaded=0, image_out_valid=0, image_out=0; pix_in_ready follows enable.
//   Bank RAM contents are not reset; they are masked by valid.
//  Accept = pix_in_valid & pix_in_ready. Nothing happens without accept.
//  Write FSM:
//   IDLE: accept w/o sof -> pixel discarded, stay. Accept with sof -> write bank[wr_bank][0][0],
//    col=1, row=0 (WIDTH=1: row=1, col=0), go FILL.
//   FILL: accept w/o sof -> write bank[wr_bank][row][col]; col++; on col==WIDTH-1 col=0,row++.
//    Accept with sof -> frame_err=1 next cycle, restart: pixel written to (0,0), col=1,row=0.
//    Accept of (HEIGHT-1,WIDTH-1) -> full[wr_bank]<=1, wr_bank toggles, row=col=0,
//    tiles_loaded++, go IDLE. A 1x1 tile completes on its sof pixel directly from IDLE.
//  Output side: image_out = full[rd_bank] ? bank[rd_bank] : 0.
//   image_out_ack while image_out_valid=1 -> full[rd_bank]<=0, rd_bank toggles. Ack while
//   valid=0 is ignored.
//  Latency: last pixel accepted in cycle N -> image_out_valid=1 in cycle N+1 when that bank is
//   rd_bank; otherwise the tile appears the cycle after the ack that releases the other bank.
//  Back-pressure: both banks full -> pix_in_ready=0 until ack; ready=1 in cycle after ack.
//  Simultaneous completion (bank X) and ack (bank Y!=X) in one cycle: both updates apply.
//  image_out contents are stable for the whole time image_out_valid=1.
//  enable=0: ready=0, row/col/state held; output side (ack handling) keeps operating.
//  Reset mid-fill: partial tile discarded; the next tile needs sof.
// TESTING
//  1 Defaults, ramp p=(r*50+c)%256 with sof on first, no stalls -> valid 1 cycle after 2500th
//    accept; image_out[1][0]=50, [49][49]=195, tiles_loaded=1.
//  2 Send 3 tiles with no ack -> ready drops after 5000th accept; ack -> ready=1 next cycle,
//    image_out = tile 2 data, third tile then completes.
//  3 sof asserted again at pixel 100 (value 8'hAA) -> frame_err single pulse, tile completes
//    2500 pixels later, image_out[0][0]=8'hAA.
//  4 10 pixels without sof in IDLE then a valid tile -> stray pixels dropped, image_out = tile.
//    Ack with valid=0 -> no state change.
//  5 reset_n low at pixel 1000 of tile 2 while tile 1 presented -> valid=0, tiles_loaded=0;
//    after release, fresh tile loads correctly.
//  6 enable=0 for 20 cycles mid-tile while valid held high -> ready=0, no pixel lost or
//    duplicated; final tile exact.

Source files
------------

// File: rtl/image_tile_loader.sv
// rtl/image_tile_loader.sv - raster pixel stream to parallel HEIGHT x WIDTH tile, ping-pong buffered
module image_tile_loader #(
  parameter int HEIGHT      = 50,
  parameter int WIDTH       = 50,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             enable,
  input  logic [PIXEL_WIDTH-1:0]                           pix_in,
  input  logic                                             pix_in_valid,
  input  logic                                             pix_in_sof,
  output logic                                             pix_in_ready,
  output logic [HEIGHT-1:0][WIDTH-1:0][PIXEL_WIDTH-1:0]    image_out,
  output logic                                             image_out_valid,
  input  logic                                             image_out_ack,
  output logic                                             frame_err,
  output logic [15:0]                                      tiles_loaded
);

  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   row, row_nxt, wr_row;
  logic [CW-1:0]   col, col_nxt, wr_col;
  logic            wr_bank, rd_bank;
  logic [1:0]      full, full_nxt;
  logic            accept, wr_en, complete, restart, rd_release;

  logic [PIXEL_WIDTH-1:0] bank [2][HEIGHT][WIDTH];

  assign pix_in_ready    = enable & ~full[wr_bank];
  assign accept          = pix_in_valid & pix_in_ready;
  assign image_out_valid = full[rd_bank];
  assign rd_release      = image_out_ack & full[rd_bank];

  // A sof pixel always lands at (0,0); anything else only counts while a tile is open.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    wr_en     = 1'b0;
    wr_row    = row;
    wr_col    = col;
    complete  = 1'b0;
    restart   = 1'b0;
    if (accept) begin
      if (pix_in_sof) begin
        wr_en   = 1'b1;
        wr_row  = '0;
        wr_col  = '0;
        restart = (state == FILL);
      end else if (state == FILL) begin
        wr_en = 1'b1;
      end
      if (wr_en) begin
        if (wr_row == ROW_LAST && wr_col == COL_LAST) begin
          complete  = 1'b1;
          row_nxt   = '0;
          col_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          state_nxt = FILL;
          if (wr_col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = wr_row + 1'b1;
          end else begin
            col_nxt = wr_col + 1'b1;
            row_nxt = wr_row;
          end
        end
      end
    end
  end

  // Completion needs the write bank empty and release needs the read bank full, so they never collide.
  always_comb begin
    full_nxt = full;
    if (complete)   full_nxt[wr_bank] = 1'b1;
    if (rd_release) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      full         <= 2'b00;
      frame_err    <= 1'b0;
      tiles_loaded <= 16'd0;
    end else begin
      state        <= state_nxt;
      row          <= row_nxt;
      col          <= col_nxt;
      wr_bank      <= wr_bank ^ complete;
      rd_bank      <= rd_bank ^ rd_release;
      full         <= full_nxt;
      frame_err    <= restart;
      tiles_loaded <= tiles_loaded + {15'd0, complete};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) bank[wr_bank][wr_row][wr_col] <= pix_in;
  end

  always_comb begin
    image_out = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        image_out[r][c] = full[rd_bank] ? bank[rd_bank][r][c] : '0;
      end
    end
  end

endmodule

// File: tb/tb_image_tile_loader.sv
// tb/tb_image_tile_loader.sv - directed self-checking bench for image_tile_loader
module tb_image_tile_loader;

  localparam int H = 50;
  localparam int W = 50;
  localparam int N = H * W;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     enable;
  logic [7:0]               pix_in;
  logic                     pix_in_valid;
  logic                     pix_in_sof;
  logic                     pix_in_ready;
  logic [H-1:0][W-1:0][7:0] image_out;
  logic                     image_out_valid;
  logic                     image_out_ack;
  logic                     frame_err;
  logic [15:0]              tiles_loaded;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_t [3][H][W];

  image_tile_loader #(.HEIGHT(H), .WIDTH(W), .PIXEL_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_sof(pix_in_sof),
    .pix_in_ready(pix_in_ready), .image_out(image_out),
    .image_out_valid(image_out_valid), .image_out_ack(image_out_ack),
    .frame_err(frame_err), .tiles_loaded(tiles_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void fill(input int k, input int seed);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_t[k][r][c] = 8'((r * W + c + seed) % 256);
  endfunction

  function automatic int mism(input int k);
    int n = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (image_out[r][c] !== exp_t[k][r][c]) n++;
    return n;
  endfunction

  // Holds the pixel until the DUT takes it; ready is sampled mid-cycle.
  task automatic push(input logic [7:0] p, input logic s);
    int budget = 0;
    logic acc;
    pix_in = p;
    pix_in_sof = s;
    pix_in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = pix_in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 200);
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic send_range(input int k, input int from, input int to);
    for (int i = from; i < to; i++)
      push(exp_t[k][i / W][i % W], i == 0);
    pix_in_valid = 1'b0;
    pix_in_sof = 1'b0;
  endtask

  task automatic send_tile(input int k);
    send_range(k, 0, N);
  endtask

  task automatic ack_pulse();
    image_out_ack = 1'b1;
    @(posedge clk);
    #1;
    image_out_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b1;
    pix_in = '0;
    pix_in_valid = 1'b0;
    pix_in_sof = 1'b0;
    image_out_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    do_reset();
    check("rst_valid", image_out_valid, 0);
    check("rst_ready", pix_in_ready, 1);
    check("rst_tiles", tiles_loaded, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_img", |image_out, 0);

    // 1: ramp tile, valid one cycle after the last accept
    fill(0, 0);
    send_range(0, 0, N - 1);
    check("t1_valid_early", image_out_valid, 0);
    send_range(0, N - 1, N);
    check("t1_valid", image_out_valid, 1);
    check("t1_px_1_0", image_out[1][0], 50);
    check("t1_px_49_49", image_out[49][49], 195);
    check("t1_tiles", tiles_loaded, 1);
    check("t1_tile", mism(0), 0);

    // 2: back-pressure with both banks full
    do_reset();
    fill(0, 3); fill(1, 100); fill(2, 200);
    send_tile(0);
    check("t2_valid", image_out_valid, 1);
    send_tile(1);
    check("t2_ready_low", pix_in_ready, 0);
    check("t2_tiles2", tiles_loaded, 2);
    check("t2_tileA", mism(0), 0);
    pix_in = exp_t[2][0][0];
    pix_in_sof = 1'b1;
    pix_in_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("t2_stall_ready", pix_in_ready, 0);
    check("t2_stall_tiles", tiles_loaded, 2);
    ack_pulse();
    check("t2_ready_after_ack", pix_in_ready, 1);
    check("t2_tileB", mism(1), 0);
    send_tile(2);
    check("t2_tiles3", tiles_loaded, 3);
    check("t2_ready_full_again", pix_in_ready, 0);
    check("t2_tileB_stable", mism(1), 0);
    ack_pulse();
    check("t2_tileC", mism(2), 0);

    // 3: sof mid-tile restarts and pulses frame_err
    do_reset();
    fill(0, 50);
    send_range(0, 0, 100);
    exp_t[0][0][0] = 8'hAA;
    send_range(0, 0, 1);
    check("t3_ferr_pulse", frame_err, 1);
    check("t3_tiles0", tiles_loaded, 0);
    send_range(0, 1, 2);
    check("t3_ferr_clear", frame_err, 0);
    send_range(0, 2, N);
    check("t3_tiles1", tiles_loaded, 1);
    check("t3_px00", image_out[0][0], 8'hAA);
    check("t3_tile", mism(0), 0);

    // 4: stray pixels in IDLE and ack without valid
    do_reset();
    for (int i = 0; i < 10; i++) push(8'h5A, 1'b0);
    pix_in_valid = 1'b0;
    check("t4_stray_valid", image_out_valid, 0);
    check("t4_stray_tiles", tiles_loaded, 0);
    ack_pulse();
    check("t4_ack_valid", image_out_valid, 0);
    check("t4_ack_ready", pix_in_ready, 1);
    fill(1, 77);
    send_tile(1);
    check("t4_valid", image_out_valid, 1);
    check("t4_tiles", tiles_loaded, 1);
    check("t4_tile", mism(1), 0);

    // 5: reset mid-fill while a tile is presented
    do_reset();
    fill(0, 9); fill(1, 150); fill(2, 222);
    send_tile(0);
    send_range(1, 0, 1000);
    reset_n = 1'b0;
    #1;
    check("t5_rst_valid", image_out_valid, 0);
    check("t5_rst_tiles", tiles_loaded, 0);
    check("t5_rst_img", |image_out, 0);
    check("t5_rst_ready", pix_in_ready, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_tile(2);
    check("t5_tiles", tiles_loaded, 1);
    check("t5_tile", mism(2), 0);

    // 6: enable low mid-tile with valid held
    do_reset();
    fill(0, 61);
    send_range(0, 0, 1200);
    pix_in = exp_t[0][1200 / W][1200 % W];
    pix_in_sof = 1'b0;
    pix_in_valid = 1'b1;
    enable = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (pix_in_ready) cnt++;
      @(posedge clk);
      #1;
    end
    check("t6_ready_low", cnt, 0);
    enable = 1'b1;
    send_range(0, 1200, N);
    check("t6_tiles", tiles_loaded, 1);
    check("t6_tile", mism(0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
